// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, error codes,
// common keyboard command bytes and the host-to-device frame builder.
package ps2_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_INHIBIT   = 3'd1;
  localparam state_t ST_REQ       = 3'd2;
  localparam state_t ST_SEND      = 3'd3;
  localparam state_t ST_WAIT_IDLE = 3'd4;
  localparam state_t ST_FAIL      = 3'd5;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_NACK    = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_code_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] ACK_BYTE     = 8'hFA;

  // {stop, odd parity, data[7:0], start}; bit 0 goes on the wire first.
  function automatic logic [10:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ~^data, data, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 pin plus falling-edge detect on the
// synchronized value. Also used by the keyboard receiver.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic line_sync,
  output logic line_fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // prev follows sync every cycle, so a host-side release is never seen as a fall.
  always_comb begin
    meta_d = line_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign line_sync = sync_q;
  assign line_fall = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain pull-low enables.
// Define PS2_TX_RETRY_EN to retry NACK/timeout failures up to MAX_RETRIES times.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES       = 3000,
  parameter int SETUP_CYCLES         = 25,
  parameter int START_TIMEOUT_CYCLES = 375000,
  parameter int XFER_TIMEOUT_CYCLES  = 50000,
  parameter int MAX_RETRIES          = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int MAX_AB  = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int MAX_CD  = (START_TIMEOUT_CYCLES > XFER_TIMEOUT_CYCLES) ?
                           START_TIMEOUT_CYCLES : XFER_TIMEOUT_CYCLES;
  localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic clk_sync, clk_fall;
  logic dat_sync, dat_fall_unused;

  ps2_line_sync u_clk_sync (
    .clk       (clk),
    .reset     (reset),
    .line_in   (ps2_clk_in),
    .line_sync (clk_sync),
    .line_fall (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clk       (clk),
    .reset     (reset),
    .line_in   (ps2_dat_in),
    .line_sync (dat_sync),
    .line_fall (dat_fall_unused)
  );

  state_t           state_q, state_d;
  logic [10:0]      shift_q, shift_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  err_code_t        err_code_q, err_code_d;
  logic             tx_done_q, tx_done_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;

`ifdef PS2_TX_RETRY_EN
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [7:0]         data_q, data_d;
`endif

  logic             fail;
  err_code_t        fail_code;
  logic [CNT_W-1:0] timeout_lim;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    cnt_d      = cnt_q;
    err_code_d = err_code_q;
    tx_done_d  = 1'b0;
    fail       = 1'b0;
    fail_code  = ERR_NONE;
`ifdef PS2_TX_RETRY_EN
    retry_d    = retry_q;
    data_d     = data_q;
`endif
    // Before the first device fall the long start window applies; after it, the transfer window.
    timeout_lim = (bit_cnt_q == 4'd0) ? CNT_W'(START_TIMEOUT_CYCLES - 1)
                                      : CNT_W'(XFER_TIMEOUT_CYCLES - 1);

    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          state_d    = ST_INHIBIT;
          shift_d    = ps2_frame(tx_data);
          bit_cnt_d  = 4'd0;
          cnt_d      = '0;
          err_code_d = ERR_NONE;
`ifdef PS2_TX_RETRY_EN
          retry_d    = '0;
          data_d     = tx_data;
`endif
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          state_d = ST_REQ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REQ: begin
        if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
          state_d = ST_SEND;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SEND: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == timeout_lim) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end else if (clk_fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd0) begin
            cnt_d = '0;
          end
          if (bit_cnt_q == 4'd10) begin
            if (dat_sync) begin
              fail      = 1'b1;
              fail_code = ERR_NACK;
            end else begin
              state_d = ST_WAIT_IDLE;
            end
          end else begin
            shift_d = {1'b1, shift_q[10:1]};
          end
        end
      end
      ST_WAIT_IDLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == timeout_lim) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end else if (clk_sync && dat_sync) begin
          tx_done_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_FAIL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (fail) begin
      err_code_d = fail_code;
`ifdef PS2_TX_RETRY_EN
      if (retry_q < RETRY_W'(MAX_RETRIES)) begin
        retry_d   = retry_q + RETRY_W'(1);
        state_d   = ST_INHIBIT;
        cnt_d     = '0;
        bit_cnt_d = 4'd0;
        shift_d   = ps2_frame(data_q);
      end else begin
        state_d = ST_FAIL;
      end
`else
      state_d = ST_FAIL;
`endif
    end

    // Line enables are decoded from the next state so they switch with the state register.
    clk_oe_d = (state_d == ST_INHIBIT) || (state_d == ST_REQ);
    dat_oe_d = (state_d == ST_REQ) || ((state_d == ST_SEND) && !shift_d[0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '1;
      bit_cnt_q  <= 4'd0;
      cnt_q      <= '0;
      err_code_q <= ERR_NONE;
      tx_done_q  <= 1'b0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q    <= '0;
      data_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      cnt_q      <= cnt_d;
      err_code_q <= err_code_d;
      tx_done_q  <= tx_done_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
`ifdef PS2_TX_RETRY_EN
      retry_q    <= retry_d;
      data_q     <= data_d;
`endif
    end
  end

  assign tx_ready   = (state_q == ST_IDLE);
  assign tx_busy    = ~tx_ready;
  assign tx_done    = tx_done_q;
  assign tx_err     = (state_q == ST_FAIL);
  assign err_code   = err_code_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 keyboard on the
// wire-AND bus; follows PS2_TX_RETRY_EN when the design is built with it.
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, tx_busy, tx_done, tx_err;
  logic [1:0] err_code;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk, dev_dat;
  logic       clk_line, dat_line;

  int tests_run = 0;
  int failed = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int inhibit_cnt = 0;
  logic clk_oe_prev = 1'b0;

`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  localparam logic [10:0] FRAME_ED = 11'b11111011010;
  localparam logic [10:0] FRAME_F4 = 11'b10111101000;
  localparam logic [10:0] FRAME_00 = 11'b11000000000;

  assign clk_line = dev_clk & ~ps2_clk_oe;
  assign dat_line = dev_dat & ~ps2_dat_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES       (8),
    .SETUP_CYCLES         (2),
    .START_TIMEOUT_CYCLES (200),
    .XFER_TIMEOUT_CYCLES  (400),
    .MAX_RETRIES          (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .err_code   (err_code),
    .ps2_clk_in (clk_line),
    .ps2_dat_in (dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_err) err_cnt++;
    if (tx_done && tx_err) both_cnt++;
    if (ps2_clk_oe && !clk_oe_prev) inhibit_cnt++;
    clk_oe_prev = ps2_clk_oe;
  end

  task automatic send_byte(input logic [7:0] d);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Keyboard model: waits for the request-to-send, clocks n_falls bits and
  // records the start bit plus the line value after each rising edge.
  task automatic dev_run(input int n_falls, input bit ack, output logic [10:0] bits);
    int waited;
    waited = 0;
    bits = '0;
    while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    tests_run++;
    if (waited >= 200) begin
      $display("FAIL dev_wait_rts: clk_oe=%b dat_oe=%b, required clk_oe=0 dat_oe=1",
               ps2_clk_oe, ps2_dat_oe);
      failed++;
      return;
    end
    repeat (5) @(negedge clk);
    bits[0] = dat_line;
    for (int i = 1; i <= n_falls; i++) begin
      if (i == 11) begin
        dev_dat = ack ? 1'b0 : 1'b1;
        repeat (3) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (10) @(negedge clk);
      dev_clk = 1'b1;
      @(negedge clk);
      if (i <= 10) bits[i] = dat_line;
      repeat (9) @(negedge clk);
    end
    dev_dat = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
      $display("FAIL reset_ready: ready=%b busy=%b, required ready=1 busy=0", tx_ready, tx_busy);
      failed++;
    end
    tests_run++;
    if (tx_done !== 1'b0 || tx_err !== 1'b0 || err_code !== 2'd0) begin
      $display("FAIL reset_flags: done=%b err=%b code=%0d, required 0 0 0", tx_done, tx_err, err_code);
      failed++;
    end
    tests_run++;
    if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
      $display("FAIL reset_oe: clk_oe=%b dat_oe=%b, required 0 0", ps2_clk_oe, ps2_dat_oe);
      failed++;
    end
  endtask

  task automatic test_send_leds();
    logic [10:0] bits;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'hED);
    tests_run++;
    if (tx_ready !== 1'b0 || tx_busy !== 1'b1) begin
      $display("FAIL leds_busy: ready=%b busy=%b, required ready=0 busy=1", tx_ready, tx_busy);
      failed++;
    end
    dev_run(11, 1'b1, bits);
    tests_run++;
    if (bits !== FRAME_ED) begin
      $display("FAIL leds_bits: got %b, required %b", bits, FRAME_ED);
      failed++;
    end
    repeat (30) @(negedge clk);
    tests_run++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
      $display("FAIL leds_done: done cycles=%0d err cycles=%0d, required 1 0", done_cnt - d0, err_cnt - e0);
      failed++;
    end
    tests_run++;
    if (tx_ready !== 1'b1 || err_code !== 2'd0) begin
      $display("FAIL leds_idle: ready=%b code=%0d, required ready=1 code=0", tx_ready, err_code);
      failed++;
    end
  endtask

  task automatic test_request_timing();
    logic [10:0] clk_vec, dat_vec, bits;
    int d0;
    d0 = done_cnt;
    send_byte(8'hF4);
    for (int k = 0; k <= 10; k++) begin
      clk_vec[k] = ps2_clk_oe;
      dat_vec[k] = ps2_dat_oe;
      if (k < 10) @(negedge clk);
    end
    tests_run++;
    if (clk_vec !== 11'b01111111111) begin
      $display("FAIL rts_clk_oe: got %b, required %b", clk_vec, 11'b01111111111);
      failed++;
    end
    tests_run++;
    if (dat_vec !== 11'b11100000000) begin
      $display("FAIL rts_dat_oe: got %b, required %b", dat_vec, 11'b11100000000);
      failed++;
    end
    dev_run(11, 1'b1, bits);
    tests_run++;
    if (bits !== FRAME_F4) begin
      $display("FAIL rts_bits: got %b, required %b", bits, FRAME_F4);
      failed++;
    end
    repeat (30) @(negedge clk);
    tests_run++;
    if (done_cnt - d0 != 1) begin
      $display("FAIL rts_done: done cycles=%0d, required 1", done_cnt - d0);
      failed++;
    end
  endtask

  task automatic test_nack();
    logic [10:0] bits;
    int d0, e0, i0;
    d0 = done_cnt;
    e0 = err_cnt;
    i0 = inhibit_cnt;
    send_byte(8'h00);
    for (int a = 0; a < ATTEMPTS; a++) begin
      dev_run(11, 1'b0, bits);
      tests_run++;
      if (bits !== FRAME_00) begin
        $display("FAIL nack_bits attempt %0d: got %b, required %b", a, bits, FRAME_00);
        failed++;
      end
    end
    repeat (20) @(negedge clk);
    tests_run++;
    if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
      $display("FAIL nack_pulse: err cycles=%0d done cycles=%0d, required 1 0", err_cnt - e0, done_cnt - d0);
      failed++;
    end
    tests_run++;
    if (err_code !== 2'd1) begin
      $display("FAIL nack_code: got %0d, required 1", err_code);
      failed++;
    end
    tests_run++;
    if (inhibit_cnt - i0 != ATTEMPTS) begin
      $display("FAIL nack_inhibits: got %0d, required %0d", inhibit_cnt - i0, ATTEMPTS);
      failed++;
    end
  endtask

  task automatic test_timeout();
    int waited;
    int i0;
    i0 = inhibit_cnt;
    send_byte(8'hFF);
    waited = 0;
    while (ps2_clk_oe !== 1'b0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    tests_run++;
    if (waited >= 50) begin
      $display("FAIL timeout_release: clk_oe=%b, required 0", ps2_clk_oe);
      failed++;
    end
    repeat (200) @(negedge clk);
`ifdef PS2_TX_RETRY_EN
    tests_run++;
    if (ps2_clk_oe !== 1'b1 || tx_err !== 1'b0 || err_code !== 2'd2) begin
      $display("FAIL timeout_retry: clk_oe=%b err=%b code=%0d, required 1 0 2", ps2_clk_oe, tx_err, err_code);
      failed++;
    end
    waited = 0;
    while (tx_err !== 1'b1 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    tests_run++;
    if (tx_err !== 1'b1 || inhibit_cnt - i0 != 3) begin
      $display("FAIL timeout_final: err=%b inhibits=%0d, required 1 3", tx_err, inhibit_cnt - i0);
      failed++;
    end
`else
    tests_run++;
    if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || tx_err !== 1'b1) begin
      $display("FAIL timeout_fail: clk_oe=%b dat_oe=%b err=%b, required 0 0 1", ps2_clk_oe, ps2_dat_oe, tx_err);
      failed++;
    end
    tests_run++;
    if (inhibit_cnt - i0 != 1) begin
      $display("FAIL timeout_inhibits: got %0d, required 1", inhibit_cnt - i0);
      failed++;
    end
`endif
    tests_run++;
    if (err_code !== 2'd2) begin
      $display("FAIL timeout_code: got %0d, required 2", err_code);
      failed++;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [10:0] bits;
    int d0, e0;
    send_byte(8'hED);
    dev_run(4, 1'b1, bits);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || tx_ready !== 1'b1) begin
      $display("FAIL midreset_idle: clk_oe=%b dat_oe=%b ready=%b, required 0 0 1", ps2_clk_oe, ps2_dat_oe, tx_ready);
      failed++;
    end
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'hF4);
    dev_run(11, 1'b1, bits);
    tests_run++;
    if (bits !== FRAME_F4) begin
      $display("FAIL midreset_bits: got %b, required %b", bits, FRAME_F4);
      failed++;
    end
    repeat (30) @(negedge clk);
    tests_run++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
      $display("FAIL midreset_done: done cycles=%0d err cycles=%0d, required 1 0", done_cnt - d0, err_cnt - e0);
      failed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] bits;
    int d0;
    d0 = done_cnt;
    send_byte(8'hED);
    fork
      dev_run(11, 1'b1, bits);
      begin
        repeat (30) @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hF4;
        repeat (3) @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    tests_run++;
    if (bits !== FRAME_ED) begin
      $display("FAIL b2b_bits: got %b, required %b", bits, FRAME_ED);
      failed++;
    end
    repeat (30) @(negedge clk);
    tests_run++;
    if (done_cnt - d0 != 1) begin
      $display("FAIL b2b_done: done cycles=%0d, required 1", done_cnt - d0);
      failed++;
    end
    tests_run++;
    if (tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0) begin
      $display("FAIL b2b_idle: ready=%b clk_oe=%b, required 1 0", tx_ready, ps2_clk_oe);
      failed++;
    end
  endtask

  initial begin
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_dat  = 1'b1;
    test_reset();
    test_send_leds();
    test_request_timing();
    test_nack();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    tests_run++;
    if (both_cnt != 0) begin
      $display("FAIL done_err_overlap: cycles=%0d, required 0", both_cnt);
      failed++;
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
